sdram_model: RTL and testbench
==============================

# sdram_model

Cycle-accurate, bus-level model of a single-rank 16-bit SDR SDRAM device. It is the responder to the team's SDRAM controller and sits on the `dr_*` pins in system simulation and in controller regression benches. It decodes commands and tracks the power-up sequence, mode register and per-bank row state. It stores write data, returns read data at the programmed CAS latency, and flags the first protocol or timing violation it detects.

## Interface
- `COL_BITS`, default 9: column address width (`dr_a[COL_BITS-1:0]`).
- `STORE_BITS`, default 16: storage depth is 2^STORE_BITS words, indexed by `{ba,row,col}[STORE_BITS-1:0]`. Aliasing above that depth is intended.
- `TRCD`, default 2: minimum edges from ACTIVE to READ/WRITE on the same bank.
- `TRP`, default 2: minimum edges from PRECHARGE to ACTIVE/REFRESH/LOAD MODE.
- `TAP`, default 2: minimum edges from READ/WRITE with auto-precharge to the next ACTIVE on that bank.
- `TRFC`, default 4: minimum edges from REFRESH to any non-NOP command.
- `TMRD`, default 2: minimum edges from LOAD MODE to any non-NOP command.
- `TREFI`, default 400: maximum edges between REFRESH commands once `init_done` is asserted.

Ports (clock and reset first):
- `clk` in 1: the single clock. All commands are sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dr_cke` in 1: clock enable. When 0, the command is treated as deselect.
- `dr_cs_n` in 1: chip select. When 1, the command is deselect (NOP).
- `dr_ras_n`, `dr_cas_n`, `dr_we_n` in 1 each: command bits.
- `dr_ba` in 2: bank address.
- `dr_a` in 13: row address, column address, or mode value. `dr_a[10]` is the auto-precharge / all-banks bit.
- `dr_dqml`, `dr_dqmh` in 1 each: byte masks for `dq[7:0]` and `dq[15:8]`. 1 = masked.
- `dr_dq` inout 16: data bus.
- `init_done` out 1: high once the power-up sequence has completed.
- `err` out 1: sticky violation flag.
- `err_code` out 4: code of the first violation detected.
- `refresh_cnt` out 16: number of REFRESH commands accepted (wraps).

## Operation
- Command decode uses `{ras_n,cas_n,we_n}`:
  - 111: NOP
  - 011: ACTIVE
  - 101: READ
  - 100: WRITE
  - 010: PRECHARGE
  - 001: REFRESH
  - 000: LOAD MODE
  - 110: burst terminate, unsupported, error code 8.
- Init FSM has four states: `NEED_PALL`, `NEED_REF` (counts 2 REFRESH), `NEED_MRS`, `READY`.
  - `NEED_PALL` → `NEED_REF` on PRECHARGE with `a[10]`=1.
  - `NEED_REF` → `NEED_MRS` after the second REFRESH.
  - `NEED_MRS` → `READY` on a LOAD MODE with a supported value.
  - ACTIVE, READ or WRITE before `READY` raises error code 1.
- Mode register, loaded on LOAD MODE:
  - `a[2:0]` must be 000 (burst length 1).
  - `a[6:4]` must be 010 (CL2) or 011 (CL3).
  - Any other value raises error code 8.
  - `a[3]` and `a[9]` are ignored.
- Per-bank state: idle/active flag, open row, and a cycles-since-last-command counter that saturates.
  - ACTIVE on an active bank: error code 2.
  - READ/WRITE on an idle bank: error code 3.
  - READ/WRITE sooner than TRCD after ACTIVE: error code 4.
  - ACTIVE sooner than TRP after precharge, or sooner than TAP after auto-precharge: error code 5.
- PRECHARGE applies to all banks when `a[10]`=1, otherwise to bank `ba`. Precharging an idle bank is legal.
- READ/WRITE with `a[10]`=1 returns the bank to idle.
- REFRESH with any bank active: error code 6.
- LOAD MODE with any bank active: error code 9.
- Any non-NOP command violating TRFC or TMRD: error code 10.
- In `READY`, if TREFI edges pass without a REFRESH: error code 7.
- Write: data is captured at the WRITE edge. Bytes whose DQM bit is 1 are left unchanged.
- Read: the addressed word is looked up at the READ edge. DQM is sampled at the READ edge, and masked bytes are returned as Z.
- Error reporting: only the first error loads `err_code`. `err` stays high until `rst`.

## Timing
- Reset values: `dr_dq` Z, `init_done` 0, `err` 0, `err_code` 0, `refresh_cnt` 0.
- Reset clears the init FSM, bank states, timers and the read pipeline. Memory contents are kept.
- Reset during a read releases `dr_dq` at that same edge.
- `init_done` rises in the cycle after the accepted LOAD MODE edge.
- Read data for a READ at edge e:
  - driven from edge e+CL-1 to edge e+CL, so it is valid at edge e+CL;
  - Z before and after that window.
- A WRITE at the edge where the model is driving read data is bus contention: error code 11. The write still occurs.
- Back-to-back READs pipeline independently; one is issued per edge at most.

## Test plan
- Init: `rst`, then PRECHARGE with `a[10]`=1, NOP, REFRESH, 4 NOPs, REFRESH, 4 NOPs, LOAD MODE `a`=0x220 → `init_done`=1 the next cycle, `err`=0, `refresh_cnt`=2.
- Write/read: ACTIVE ba=1 row 0x0123, NOP, WRITE col 0x045 `a[10]`=1 dq=0xBEEF dqm=00, NOP ×2, ACTIVE, NOP, READ col 0x045 → `dr_dq`=0xBEEF at the 2nd edge after READ and Z otherwise.
- Byte mask and CL3: WRITE 0x1234 with dqml=1, dqmh=0 over 0xBEEF; LOAD MODE 0x230 with all banks idle; read back → 0x12EF at the 3rd edge after READ.
- Timing violation: READ one edge after ACTIVE → `err`=1, `err_code`=4. A following ACTIVE to the same active bank leaves the code at 4. `rst` clears both.
- Refresh: no REFRESH for 401 edges after `init_done` → `err_code`=7. In a fresh run, REFRESH with bank 0 active → `err_code`=6.
- Pre-init access: ACTIVE before LOAD MODE → `err_code`=1 and `init_done` stays 0.

Source files
------------

// File: rtl/sdram_model.sv
// rtl/sdram_model.sv - bus-level SDR SDRAM responder with init tracking, timing checks and data store
// Reads return at the programmed CAS latency; only the first protocol violation is latched.
module sdram_model #(
  parameter int COL_BITS   = 9,
  parameter int STORE_BITS = 16,
  parameter int TRCD       = 2,
  parameter int TRP        = 2,
  parameter int TAP        = 2,
  parameter int TRFC       = 4,
  parameter int TMRD       = 2,
  parameter int TREFI      = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dr_cke,
  input  logic        dr_cs_n,
  input  logic        dr_ras_n,
  input  logic        dr_cas_n,
  input  logic        dr_we_n,
  input  logic [1:0]  dr_ba,
  input  logic [12:0] dr_a,
  input  logic        dr_dqml,
  input  logic        dr_dqmh,
  inout  wire  [15:0] dr_dq,
  output logic        init_done,
  output logic        err,
  output logic [3:0]  err_code,
  output logic [15:0] refresh_cnt
);

  localparam logic [7:0]  TRCD_M1 = 8'(TRCD - 1);
  localparam logic [7:0]  TRP_M1  = 8'(TRP - 1);
  localparam logic [7:0]  TAP_M1  = 8'(TAP - 1);
  localparam logic [7:0]  TRFC_M1 = 8'(TRFC - 1);
  localparam logic [7:0]  TMRD_M1 = 8'(TMRD - 1);
  localparam logic [15:0] TREFI_L = 16'(TREFI);

  typedef enum logic [1:0] {NEED_PALL, NEED_REF, NEED_MRS, READY} init_e;

  init_e       state_q, state_d;
  logic        ref_seen_q, ref_seen_d;
  logic        cl3_q, cl3_d;
  logic [3:0]  bank_act_q, bank_act_d;
  logic [3:0]  bank_ap_q, bank_ap_d;
  logic [12:0] bank_row_q [4];
  logic [12:0] bank_row_d [4];
  logic [7:0]  bank_cnt_q [4];
  logic [7:0]  bank_cnt_d [4];
  logic [7:0]  gcnt_q, gcnt_d;
  logic [7:0]  greq_q, greq_d;
  logic [15:0] trefi_q, trefi_d;
  logic        err_q, err_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        p1_v_q, p1_v_d, p0_v_q, p0_v_d, out_v_q, out_v_d;
  logic [15:0] p1_dat_q, p1_dat_d, p0_dat_q, p0_dat_d, out_dat_q, out_dat_d;
  logic [1:0]  p1_m_q, p1_m_d, p0_m_q, p0_m_d, out_m_q, out_m_d;

  logic [15:0] mem [2**STORE_BITS];

  logic                  sel, ready, any_act, mode_ok, rd_go, wr_go;
  logic                  cmd_any, cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_bst;
  logic [2:0]            cmd;
  logic [STORE_BITS-1:0] addr;
  logic [15:0]           rd_word;

  assign sel     = dr_cke & ~dr_cs_n;
  assign cmd     = {dr_ras_n, dr_cas_n, dr_we_n};
  assign cmd_any = sel && (cmd != 3'b111);
  assign cmd_act = sel && (cmd == 3'b011);
  assign cmd_rd  = sel && (cmd == 3'b101);
  assign cmd_wr  = sel && (cmd == 3'b100);
  assign cmd_pre = sel && (cmd == 3'b010);
  assign cmd_ref = sel && (cmd == 3'b001);
  assign cmd_lmr = sel && (cmd == 3'b000);
  assign cmd_bst = sel && (cmd == 3'b110);

  assign ready   = (state_q == READY);
  assign any_act = |bank_act_q;
  assign mode_ok = (dr_a[2:0] == 3'b000) && ((dr_a[6:4] == 3'b010) || (dr_a[6:4] == 3'b011));
  assign rd_go   = cmd_rd && ready && bank_act_q[dr_ba];
  assign wr_go   = cmd_wr && ready && bank_act_q[dr_ba];
  // Depth above STORE_BITS aliases by plain truncation of {ba,row,col}.
  assign addr    = STORE_BITS'({dr_ba, bank_row_q[dr_ba], dr_a[COL_BITS-1:0]});
  assign rd_word = mem[addr];

  always_comb begin
    logic       viol;
    logic [3:0] vcode;
    logic       trp_pend;
    logic       act_soon;

    state_d    = state_q;
    ref_seen_d = ref_seen_q;
    cl3_d      = cl3_q;
    bank_act_d = bank_act_q;
    bank_ap_d  = bank_ap_q;
    gcnt_d     = (gcnt_q == 8'hFF) ? gcnt_q : gcnt_q + 8'd1;
    greq_d     = greq_q;
    trefi_d    = (ready && trefi_q != 16'hFFFF) ? trefi_q + 16'd1 : trefi_q;
    err_d      = err_q;
    code_d     = code_q;
    rcnt_d     = rcnt_q;
    trp_pend   = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bank_row_d[b] = bank_row_q[b];
      bank_cnt_d[b] = (bank_cnt_q[b] == 8'hFF) ? bank_cnt_q[b] : bank_cnt_q[b] + 8'd1;
      if (!bank_ap_q[b] && bank_cnt_q[b] < TRP_M1) trp_pend = 1'b1;
    end
    act_soon = bank_cnt_q[dr_ba] < (bank_ap_q[dr_ba] ? TAP_M1 : TRP_M1);

    viol  = 1'b1;
    vcode = 4'd0;
    if (cmd_bst)                                            vcode = 4'd8;
    else if (cmd_any && gcnt_q < greq_q)                    vcode = 4'd10;
    else if ((cmd_act || cmd_rd || cmd_wr) && !ready)       vcode = 4'd1;
    else if (cmd_act && bank_act_q[dr_ba])                  vcode = 4'd2;
    else if (cmd_act && act_soon)                           vcode = 4'd5;
    else if ((cmd_rd || cmd_wr) && !bank_act_q[dr_ba])      vcode = 4'd3;
    else if ((cmd_rd || cmd_wr) && bank_cnt_q[dr_ba] < TRCD_M1) vcode = 4'd4;
    else if (cmd_ref && any_act)                            vcode = 4'd6;
    else if (cmd_lmr && any_act)                            vcode = 4'd9;
    else if ((cmd_ref || cmd_lmr) && trp_pend)              vcode = 4'd5;
    else if (cmd_lmr && !mode_ok)                           vcode = 4'd8;
    else if (cmd_wr && out_v_q)                             vcode = 4'd11;
    else if (ready && !cmd_ref && trefi_q >= TREFI_L)       vcode = 4'd7;
    else                                                    viol  = 1'b0;
    if (viol && !err_q) begin
      err_d  = 1'b1;
      code_d = vcode;
    end

    if (cmd_act && ready && !bank_act_q[dr_ba]) begin
      bank_act_d[dr_ba] = 1'b1;
      bank_ap_d[dr_ba]  = 1'b0;
      bank_row_d[dr_ba] = dr_a;
      bank_cnt_d[dr_ba] = 8'd0;
    end
    if ((rd_go || wr_go) && dr_a[10]) begin
      bank_act_d[dr_ba] = 1'b0;
      bank_ap_d[dr_ba]  = 1'b1;
      bank_cnt_d[dr_ba] = 8'd0;
    end
    if (cmd_pre) begin
      for (int b = 0; b < 4; b++) begin
        if (dr_a[10] || 2'(b) == dr_ba) begin
          bank_act_d[b] = 1'b0;
          bank_ap_d[b]  = 1'b0;
          bank_cnt_d[b] = 8'd0;
        end
      end
      if (state_q == NEED_PALL && dr_a[10]) state_d = NEED_REF;
    end
    if (cmd_ref) begin
      gcnt_d  = 8'd0;
      greq_d  = TRFC_M1;
      trefi_d = 16'd0;
      if (!any_act) rcnt_d = rcnt_q + 16'd1;
      if (state_q == NEED_REF) begin
        if (ref_seen_q) state_d = NEED_MRS;
        ref_seen_d = 1'b1;
      end
    end
    if (cmd_lmr) begin
      gcnt_d = 8'd0;
      greq_d = TMRD_M1;
      if (mode_ok && !any_act) begin
        cl3_d = dr_a[4];
        if (state_q == NEED_MRS) begin
          state_d = READY;
          trefi_d = 16'd0;
        end
      end
    end

    // p1 -> p0 -> out: CL2 enters at p0, CL3 one stage earlier at p1.
    out_v_d   = p0_v_q;
    out_dat_d = p0_dat_q;
    out_m_d   = p0_m_q;
    p0_v_d    = p1_v_q;
    p0_dat_d  = p1_dat_q;
    p0_m_d    = p1_m_q;
    p1_v_d    = 1'b0;
    p1_dat_d  = p1_dat_q;
    p1_m_d    = p1_m_q;
    if (rd_go) begin
      if (cl3_q) begin
        p1_v_d   = 1'b1;
        p1_dat_d = rd_word;
        p1_m_d   = {dr_dqmh, dr_dqml};
      end else begin
        p0_v_d   = 1'b1;
        p0_dat_d = rd_word;
        p0_m_d   = {dr_dqmh, dr_dqml};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NEED_PALL;
      ref_seen_q <= 1'b0;
      cl3_q      <= 1'b0;
      bank_act_q <= '0;
      bank_ap_q  <= '0;
      for (int b = 0; b < 4; b++) begin
        bank_row_q[b] <= '0;
        bank_cnt_q[b] <= 8'hFF;
      end
      gcnt_q    <= 8'hFF;
      greq_q    <= 8'd0;
      trefi_q   <= 16'd0;
      err_q     <= 1'b0;
      code_q    <= 4'd0;
      rcnt_q    <= 16'd0;
      p1_v_q    <= 1'b0;
      p0_v_q    <= 1'b0;
      out_v_q   <= 1'b0;
      p1_dat_q  <= '0;
      p0_dat_q  <= '0;
      out_dat_q <= '0;
      p1_m_q    <= '0;
      p0_m_q    <= '0;
      out_m_q   <= '0;
    end else begin
      state_q    <= state_d;
      ref_seen_q <= ref_seen_d;
      cl3_q      <= cl3_d;
      bank_act_q <= bank_act_d;
      bank_ap_q  <= bank_ap_d;
      for (int b = 0; b < 4; b++) begin
        bank_row_q[b] <= bank_row_d[b];
        bank_cnt_q[b] <= bank_cnt_d[b];
      end
      gcnt_q    <= gcnt_d;
      greq_q    <= greq_d;
      trefi_q   <= trefi_d;
      err_q     <= err_d;
      code_q    <= code_d;
      rcnt_q    <= rcnt_d;
      p1_v_q    <= p1_v_d;
      p0_v_q    <= p0_v_d;
      out_v_q   <= out_v_d;
      p1_dat_q  <= p1_dat_d;
      p0_dat_q  <= p0_dat_d;
      out_dat_q <= out_dat_d;
      p1_m_q    <= p1_m_d;
      p0_m_q    <= p0_m_d;
      out_m_q   <= out_m_d;
    end
  end

  // Storage survives reset; masked bytes keep their old value.
  always_ff @(posedge clk) begin
    if (!rst && wr_go) begin
      if (!dr_dqml) mem[addr][7:0]  <= dr_dq[7:0];
      if (!dr_dqmh) mem[addr][15:8] <= dr_dq[15:8];
    end
  end

  assign dr_dq[7:0]  = (out_v_q && !out_m_q[0]) ? out_dat_q[7:0]  : 8'hzz;
  assign dr_dq[15:8] = (out_v_q && !out_m_q[1]) ? out_dat_q[15:8] : 8'hzz;

  assign init_done   = ready;
  assign err         = err_q;
  assign err_code    = code_q;
  assign refresh_cnt = rcnt_q;

endmodule

// File: tb/tb_sdram_model.sv
// tb/tb_sdram_model.sv - directed bench for sdram_model with a read-data scoreboard
module tb_sdram_model;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        cs_n = 1'b0;
  logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = '0;
  logic [12:0] a = '0;
  logic        dqml = 1'b0, dqmh = 1'b0;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_d = '0;
  wire  [15:0] dq;
  logic        init_done, err;
  logic [3:0]  err_code;
  logic [15:0] refresh_cnt;

  assign dq = tb_oe ? tb_d : 16'hzzzz;

  sdram_model dut (
    .clk(clk), .rst(rst), .dr_cke(cke), .dr_cs_n(cs_n),
    .dr_ras_n(ras_n), .dr_cas_n(cas_n), .dr_we_n(we_n),
    .dr_ba(ba), .dr_a(a), .dr_dqml(dqml), .dr_dqmh(dqmh), .dr_dq(dq),
    .init_done(init_done), .err(err), .err_code(err_code), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] model [int];
  logic [12:0] open_row [4];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          cl = 2;
  bit          chk_dq = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] aa,
                      input logic oe, input logic [15:0] d, input logic mh, input logic ml);
    logic [15:0] ex;
    exp_t        e;
    {ras_n, cas_n, we_n} = c;
    ba = b; a = aa; tb_oe = oe; tb_d = d; dqmh = mh; dqml = ml;
    @(posedge clk);
    #1;
    {ras_n, cas_n, we_n} = 3'b111;
    tb_oe = 1'b0; dqmh = 1'b0; dqml = 1'b0;
    #1;
    cyc++;
    if (chk_dq) begin
      ex = 16'hzzzz;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e  = sbq.pop_front();
        ex = e.val;
      end
      chk("dq", {16'h0, dq}, {16'h0, ex});
    end
  endtask

  function automatic int key(input logic [1:0] b, input logic [12:0] row, input logic [8:0] col);
    logic [23:0] full;
    full = {b, row, col};
    return int'(full[15:0]);
  endfunction

  task automatic nop();
    step(3'b111, 2'd0, 13'd0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic act(input logic [1:0] b, input logic [12:0] row);
    open_row[b] = row;
    step(3'b011, b, row, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] b, input logic [8:0] col, input logic ap,
                    input logic [15:0] d, input logic mh, input logic ml);
    int          k;
    logic [15:0] old;
    k   = key(b, open_row[b], col);
    old = model.exists(k) ? model[k] : 16'h0;
    if (!ml) old[7:0] = d[7:0];
    if (!mh) old[15:8] = d[15:8];
    model[k] = old;
    step(3'b100, b, {2'b00, ap, 1'b0, col}, 1'b1, d, mh, ml);
  endtask

  task automatic rd(input logic [1:0] b, input logic [8:0] col, input logic ap,
                    input logic mh, input logic ml);
    exp_t e;
    int   k;
    k     = key(b, open_row[b], col);
    e.val = model.exists(k) ? model[k] : 16'hxxxx;
    if (ml) e.val[7:0] = 8'hzz;
    if (mh) e.val[15:8] = 8'hzz;
    e.due = cyc + cl;
    sbq.push_back(e);
    step(3'b101, b, {2'b00, ap, 1'b0, col}, 1'b0, 16'h0, mh, ml);
  endtask

  task automatic pre_all();
    step(3'b010, 2'd0, 13'h400, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic refr();
    step(3'b001, 2'd0, 13'd0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic lmr(input logic [12:0] v, input int new_cl);
    step(3'b000, 2'd0, v, 1'b0, 16'h0, 1'b0, 1'b0);
    cl = new_cl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    nop();
    rst = 1'b0;
    sbq.delete();
    cl = 2;
  endtask

  task automatic do_init(input logic [12:0] mv);
    pre_all();
    nop();
    refr();
    repeat (4) nop();
    refr();
    repeat (4) nop();
    chk("init_done_before_lmr", {31'h0, init_done}, 32'h0);
    lmr(mv, 2);
  endtask

  initial begin
    do_reset();
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_err_code", {28'h0, err_code}, 32'h0);
    chk("rst_refresh_cnt", {16'h0, refresh_cnt}, 32'h0);

    do_init(13'h220);
    chk("init_done", {31'h0, init_done}, 32'h1);
    chk("init_err", {31'h0, err}, 32'h0);
    chk("init_refresh_cnt", {16'h0, refresh_cnt}, 32'h2);

    nop();
    act(2'd1, 13'h0123);
    nop();
    wr(2'd1, 9'h045, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    nop();
    nop();
    act(2'd1, 13'h0123);
    nop();
    rd(2'd1, 9'h045, 1'b0, 1'b0, 1'b0);
    nop();
    nop();
    chk("wr_rd_err", {31'h0, err}, 32'h0);

    wr(2'd1, 9'h045, 1'b1, 16'h1234, 1'b0, 1'b1);
    nop();
    nop();
    lmr(13'h230, 3);
    nop();
    act(2'd1, 13'h0123);
    nop();
    rd(2'd1, 9'h045, 1'b1, 1'b0, 1'b0);
    repeat (3) nop();
    act(2'd1, 13'h0123);
    nop();
    rd(2'd1, 9'h045, 1'b1, 1'b0, 1'b1);
    repeat (3) nop();
    chk("cl3_err", {31'h0, err}, 32'h0);

    act(2'd2, 13'h0005);
    nop();
    wr(2'd2, 9'h001, 1'b0, 16'hA5A5, 1'b0, 1'b0);
    wr(2'd2, 9'h002, 1'b0, 16'h5A5A, 1'b0, 1'b0);
    rd(2'd2, 9'h001, 1'b0, 1'b0, 1'b0);
    rd(2'd2, 9'h002, 1'b0, 1'b0, 1'b0);
    repeat (4) nop();
    pre_all();
    nop();
    refr();
    chk("b2b_err", {31'h0, err}, 32'h0);
    chk("refresh_cnt_3", {16'h0, refresh_cnt}, 32'h3);
    chk("sb_drained", sbq.size(), 32'h0);

    chk_dq = 1'b0;
    do_reset();
    do_init(13'h220);
    nop();
    act(2'd0, 13'h0007);
    rd(2'd0, 9'h000, 1'b0, 1'b0, 1'b0);
    chk("trcd_err", {31'h0, err}, 32'h1);
    chk("trcd_code", {28'h0, err_code}, 32'h4);
    act(2'd0, 13'h0007);
    chk("sticky_code", {28'h0, err_code}, 32'h4);
    do_reset();
    chk("rst_clears_err", {31'h0, err}, 32'h0);
    chk("rst_clears_code", {28'h0, err_code}, 32'h0);

    do_init(13'h220);
    repeat (400) nop();
    chk("trefi_edge_ok", {31'h0, err}, 32'h0);
    nop();
    chk("trefi_code", {28'h0, err_code}, 32'h7);

    do_reset();
    do_init(13'h220);
    nop();
    act(2'd0, 13'h0001);
    nop();
    refr();
    chk("ref_active_code", {28'h0, err_code}, 32'h6);

    do_reset();
    act(2'd0, 13'h0001);
    chk("preinit_code", {28'h0, err_code}, 32'h1);
    nop();
    nop();
    chk("preinit_init_done", {31'h0, init_done}, 32'h0);

    do_reset();
    do_init(13'h221);
    chk("bad_mode_code", {28'h0, err_code}, 32'h8);
    chk("bad_mode_init_done", {31'h0, init_done}, 32'h0);

    do_reset();
    do_init(13'h220);
    nop();
    act(2'd0, 13'h0001);
    nop();
    rd(2'd0, 9'h000, 1'b0, 1'b0, 1'b0);
    nop();
    wr(2'd0, 9'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("contention_code", {28'h0, err_code}, 32'hB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
